data_sram_responder: RTL
========================

Name: data_sram_responder

Overview:
- Target-side responder for the CPU data SRAM port: consumes en/wen/addr/wdata and returns rdata with fixed 1-cycle latency.
- Backs a word-addressed RAM plus a small MMIO register window (LED, switch, free-running timer with compare interrupt).
- Sits at SoC level directly across from the CPU data port. There is no stall/ready path, so every request completes in exactly one cycle.

Parameters:
- RAM_AW, 14, RAM word-address width; RAM holds 2^RAM_AW 32-bit words.
- MMIO_BASE, 32'hbfaf0000, MMIO window base; match on addr[31:16].

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_sram_en  in  1  request valid this cycle.
- data_sram_wen  in  4  byte write strobes; 0 means read.
- data_sram_addr  in  32  byte address; bits [1:0] ignored.
- data_sram_wdata  in  32  write data, byte lanes aligned to strobes.
- data_sram_rdata  out  32  read data, valid the cycle after the request.
- switch_in  in  8  external switches, asynchronous to clk.
- led  out  16  LED register.
- timer_irq  out  1  sticky compare-match flag (STATUS bit0).

Behaviour:
- Reset values (rst high at edge):
  - rdata=0, led=0, timer=0, timer_cmp=32'hffffffff, irq flag=0, switch synchroniser flops=0.
  - RAM contents are not reset.
  - rst has priority over any request in the same cycle; that request is dropped (no write, rdata=0 next cycle).
- Decode:
  - MMIO if addr[31:16]==MMIO_BASE[31:16].
  - Otherwise RAM at word index addr[RAM_AW+1:2]. Upper address bits are ignored, so RAM aliases/wraps.
- Read:
  - When en=1, rdata at the next edge = selected word's value before this cycle's write (read-before-write), regardless of wen.
  - When en=0, rdata holds its previous value.
- Write:
  - en=1, wen!=0: each byte lane i with wen[i]=1 updates bits [8i+7:8i] at the edge.
  - Writes to read-only or unmapped locations are ignored.
- MMIO map (offset = addr[15:0]):
  - 16'hf000 LED: RW. Bits [15:0] only; reads bits [31:16]=0; strobes wen[3:2] ignored.
  - 16'hf004 SWITCH: RO. Read {24'b0, sw_sync}. sw_sync is a 2-flop synchroniser, so a change becomes visible on the 3rd edge after it.
  - 16'hf008 TIMER: RW.
    - Increments by 1 every cycle, wrapping 32'hffffffff to 0.
    - A write in cycle N loads the byte-merged value and suppresses that cycle's increment; the timer resumes incrementing next cycle.
    - A read returns the pre-edge value from the request cycle.
  - 16'hf00c TIMER_CMP: RW, byte-strobed.
  - 16'hf010 STATUS: bit0=irq flag, other bits read 0.
    - Flag sets on the edge after a cycle where timer==timer_cmp.
    - Writing 1 to bit0 (wen[0]=1) clears it (W1C); writing 0 has no effect.
    - If set and clear occur in the same cycle, set wins.
  - Any other offset in the window reads 0; writes are ignored.
- timer_irq = irq flag, registered; no combinational path from inputs.
- Back-to-back requests every cycle are legal. A read following a write to the same address returns the new data.

Test Plan:
- Reset, then read RAM 0x00000010 -> rdata==0 is not required. Read LED -> 0; read TIMER_CMP -> 32'hffffffff; timer_irq=0.
- Write 32'h11223344 with wen=4'b1111 to 0x00000020, then write 32'haabbccdd with wen=4'b0101 to the same address, then read -> 32'h11bb33dd one cycle after the read request. Same-cycle read/write returns the old value.
- Write 32'h0000_00ff with wen=4'b1111 to the address aliasing RAM index 0 via bit RAM_AW+2 set, then read address 0 -> 32'h000000ff (wrap).
- Write TIMER=32'hfffffffe, read in each of the next 3 cycles -> fffffffe, ffffffff, 00000000.
- Write TIMER_CMP=100, TIMER=90 -> timer_irq rises exactly 11 cycles after the TIMER write edge. Write STATUS=1 -> flag clears; with timer==cmp in the clear cycle, flag stays 1.
- Drive switch_in=8'h5a; read SWITCH at edge +1 -> old value, at edge +3 -> 32'h5a. Assert rst while an LED write is pending -> led stays 0, rdata=0.

Source files
------------

// File: rtl/data_sram_responder_if.sv
// ---------------------------------------------------------------------------
// data_sram_responder_if
//   CPU data SRAM port bundle.
//   en    : request valid this cycle
//   wen   : byte write strobes, 0 means read
//   addr  : byte address, bits [1:0] ignored by the responder
//   wdata : write data, byte lanes aligned to strobes
//   rdata : read data, valid the cycle after the request
//   master = CPU side, slave = responder side.
// ---------------------------------------------------------------------------
interface data_sram_responder_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, output wen, output addr, output wdata, input rdata);
  modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
//   Target-side responder for the CPU data SRAM port. Every request completes
//   in one cycle: rdata is registered and shows the selected word as it was
//   before the request cycle's write (read-before-write).
//   Backs a 2^RAM_AW x 32 word RAM plus an MMIO window at MMIO_BASE[31:16]:
//     +f000 LED (RW, 16 bits)      +f004 SWITCH (RO, synchronised)
//     +f008 TIMER (RW, free-run)   +f00c TIMER_CMP (RW)
//     +f010 STATUS (bit0 irq flag, write-1-to-clear)
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   data_sram  : request/response bundle (slave modport)
//   switch_in  : external switches, asynchronous to clk
//   led        : LED register
//   timer_irq  : sticky timer compare-match flag
// ---------------------------------------------------------------------------
module data_sram_responder #(
  parameter int          RAM_AW    = 14,
  parameter logic [31:0] MMIO_BASE = 32'hbfaf0000
) (
  input  logic                   clk,
  input  logic                   rst,
  data_sram_responder_if.slave   data_sram,
  input  logic [7:0]             switch_in,
  output logic [15:0]            led,
  output logic                   timer_irq
);

  localparam logic [15:0] OFF_LED    = 16'hf000;
  localparam logic [15:0] OFF_SWITCH = 16'hf004;
  localparam logic [15:0] OFF_TIMER  = 16'hf008;
  localparam logic [15:0] OFF_CMP    = 16'hf00c;
  localparam logic [15:0] OFF_STATUS = 16'hf010;

  // Apply byte strobes to an existing word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // ---------------- decode ----------------
  logic              is_mmio;
  logic [15:0]       word_off;
  logic              req_wr;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_led, wr_timer, wr_cmp, wr_status, ram_wr;

  assign is_mmio   = (data_sram.addr[31:16] == MMIO_BASE[31:16]);
  assign word_off  = {data_sram.addr[15:2], 2'b00};
  assign req_wr    = data_sram.en && (data_sram.wen != 4'b0000);
  assign ram_idx   = data_sram.addr[RAM_AW+1:2];
  assign ram_wr    = req_wr && !is_mmio;
  assign wr_led    = req_wr && is_mmio && (word_off == OFF_LED);
  assign wr_timer  = req_wr && is_mmio && (word_off == OFF_TIMER);
  assign wr_cmp    = req_wr && is_mmio && (word_off == OFF_CMP);
  assign wr_status = req_wr && is_mmio && (word_off == OFF_STATUS);

  // Byte offset bits carry no information for a word-addressed target.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^data_sram.addr[1:0];

  // ---------------- state ----------------
  logic [31:0] mem_q [2**RAM_AW];
  logic [31:0] rdata_q;
  logic [15:0] led_q;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q;
  logic        irq_q;
  logic [31:0] led_merge_d;
  logic [31:0] mmio_rdata_d;

  // RAM: no reset on contents; a request coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram.wen[i]) mem_q[ram_idx][8*i +: 8] <= data_sram.wdata[8*i +: 8];
      end
    end
  end

  // MMIO read mux uses pre-edge register values, giving read-before-write.
  always_comb begin
    mmio_rdata_d = 32'h0;
    case (word_off)
      OFF_LED:    mmio_rdata_d = {16'h0, led_q};
      OFF_SWITCH: mmio_rdata_d = {24'h0, sw_sync_q};
      OFF_TIMER:  mmio_rdata_d = timer_q;
      OFF_CMP:    mmio_rdata_d = cmp_q;
      OFF_STATUS: mmio_rdata_d = {31'h0, irq_q};
      default:    mmio_rdata_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'h0;
    end else if (data_sram.en) begin
      rdata_q <= is_mmio ? mmio_rdata_d : mem_q[ram_idx];
    end
  end

  // LED only has the low two byte lanes.
  assign led_merge_d = byte_merge({16'h0, led_q}, data_sram.wdata, {2'b00, data_sram.wen[1:0]});

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= 16'h0;
    end else if (wr_led) begin
      led_q <= led_merge_d[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
    end else begin
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  // A write replaces that cycle's increment.
  assign timer_d = wr_timer ? byte_merge(timer_q, data_sram.wdata, data_sram.wen)
                            : timer_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= 32'h0;
      cmp_q   <= 32'hffff_ffff;
    end else begin
      timer_q <= timer_d;
      if (wr_cmp) cmp_q <= byte_merge(cmp_q, data_sram.wdata, data_sram.wen);
    end
  end

  // Set has priority over the write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (timer_q == cmp_q) begin
      irq_q <= 1'b1;
    end else if (wr_status && data_sram.wen[0] && data_sram.wdata[0]) begin
      irq_q <= 1'b0;
    end
  end

  assign data_sram.rdata = rdata_q;
  assign led             = led_q;
  assign timer_irq       = irq_q;

endmodule
